// File: rtl/rotate_right_seq_if.sv
// Handshake bundle for rotate_right_seq: operand channel in, result channel out.
// The producer/consumer side uses master, the rotator uses slave.
interface rotate_right_seq_if #(
    parameter int DW = 8,
    parameter int SW = 3
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [SW-1:0] n;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] y;
    logic          busy;

    modport master (
        output in_valid, a, n, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, a, n, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/rotate_right_seq.sv
// Multi-cycle right rotator: one log-stage of the rotate amount is applied per clock,
// result held with valid/ready until consumed.
module rotate_right_seq #(
    parameter int DW = 8,
    parameter int SW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    rotate_right_seq_if.slave io
);
    localparam int STG_W = (SW > 1) ? $clog2(SW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Rotation applied by stage k is 2^k reduced modulo DW (DW need not be a power of 2).
    function automatic int pow2_mod(input int k);
        int r;
        r = 1 % DW;
        for (int i = 0; i < k; i++) begin
            r = (r * 2) % DW;
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [DW-1:0]      data_q, data_d;
    logic [SW-1:0]      amt_q, amt_d;
    logic [STG_W-1:0]   stage_q, stage_d;

    logic [2*DW-1:0]    data_dbl;
    logic [DW-1:0]      rot_stage [SW];
    logic [DW-1:0]      stage_rot;
    logic               last_stage;
    logic               in_ready_c, out_valid_c, busy_c;

    assign data_dbl = {data_q, data_q};

    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_stage
            localparam int R = pow2_mod(gi);
            assign rot_stage[gi] = data_dbl[R +: DW];
        end
    endgenerate

    always_comb begin
        stage_rot = data_q;
        for (int k = 0; k < SW; k++) begin
            if (stage_q == STG_W'(k) && amt_q[k]) begin
                stage_rot = rot_stage[k];
            end
        end
    end

    assign last_stage = (stage_q == STG_W'(SW - 1));

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        amt_d       = amt_q;
        stage_d     = stage_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (io.in_valid) begin
                    data_d  = io.a;
                    amt_d   = io.n;
                    stage_d = '0;
                    state_d = ROT;
                end
            end
            ROT: begin
                busy_c = 1'b1;
                data_d = stage_rot;
                if (last_stage) begin
                    stage_d = '0;
                    state_d = HOLD;
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            HOLD: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            stage_q <= stage_d;
        end
    end

    assign io.in_ready  = in_ready_c;
    assign io.out_valid = out_valid_c;
    assign io.busy      = busy_c;
    assign io.y         = data_q;
endmodule

// File: tb/tb_rotate_right_seq.sv
// Scoreboard bench for rotate_right_seq: DW=8 and DW=5 instances, expected words queued
// at issue and compared when out_valid appears.
module tb_rotate_right_seq;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rotate_right_seq_if #(.DW(8), .SW(SW)) bus8 ();
    rotate_right_seq_if #(.DW(5), .SW(SW)) bus5 ();

    rotate_right_seq #(.DW(8), .SW(SW)) dut8 (.clk(clk), .rst_n(rst_n), .io(bus8));
    rotate_right_seq #(.DW(5), .SW(SW)) dut5 (.clk(clk), .rst_n(rst_n), .io(bus5));

    int errors = 0;
    int checks = 0;
    logic [7:0] q8 [$];
    logic [4:0] q5 [$];

    function automatic logic [7:0] rotr8(input logic [7:0] v, input int s);
        logic [7:0] r;
        int sh;
        sh = s % 8;
        for (int i = 0; i < 8; i++) r[i] = v[(i + sh) % 8];
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        logic [7:0] r;
        int sh;
        sh = s % 8;
        for (int i = 0; i < 8; i++) r[(i + sh) % 8] = v[i];
        return r;
    endfunction

    function automatic logic [4:0] rotr5(input logic [4:0] v, input int s);
        logic [4:0] r;
        int sh;
        sh = s % 5;
        for (int i = 0; i < 5; i++) r[i] = v[(i + sh) % 5];
        return r;
    endfunction

    // Issue one operand from a negedge; returns at the negedge after the accepting edge.
    task automatic start8(input logic [7:0] av, input logic [2:0] nv, input logic [7:0] exp);
        int w = 0;
        bus8.in_valid = 1'b1;
        bus8.a = av;
        bus8.n = nv;
        while (!bus8.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 20) begin
            errors++;
            $display("FAIL accept8_timeout: in_ready got %b want 1", bus8.in_ready);
        end
        q8.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
    endtask

    task automatic start5(input logic [4:0] av, input logic [2:0] nv, input logic [4:0] exp);
        int w = 0;
        bus5.in_valid = 1'b1;
        bus5.a = av;
        bus5.n = nv;
        while (!bus5.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 20) begin
            errors++;
            $display("FAIL accept5_timeout: in_ready got %b want 1", bus5.in_ready);
        end
        q5.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        bus5.in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid, bounded at 20.
    task automatic wait_out8(output int cyc);
        cyc = 0;
        while (!bus8.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_out5(output int cyc);
        cyc = 0;
        while (!bus5.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic consume8;
        bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.out_ready = 1'b0;
    endtask

    task automatic consume5;
        bus5.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus5.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0 || bus8.y !== 8'h00) begin
            errors++;
            $display("FAIL reset8: got rdy=%b vld=%b busy=%b y=%h want 1 0 0 00",
                     bus8.in_ready, bus8.out_valid, bus8.busy, bus8.y);
        end
        checks++;
        if (bus5.in_ready !== 1'b1 || bus5.out_valid !== 1'b0 || bus5.busy !== 1'b0 || bus5.y !== 5'h00) begin
            errors++;
            $display("FAIL reset5: got rdy=%b vld=%b busy=%b y=%h want 1 0 0 00",
                     bus5.in_ready, bus5.out_valid, bus5.busy, bus5.y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [7:0] ta [7] = '{8'hA5, 8'h81, 8'h5A, 8'h87, 8'h0F, 8'hFF, 8'h01};
        logic [2:0] tn [7] = '{3'd3, 3'd1, 3'd0, 3'd5, 3'd4, 3'd7, 3'd7};
        logic [7:0] te [7] = '{8'hB4, 8'hC0, 8'h5A, 8'h3C, 8'hF0, 8'hFF, 8'h02};
        logic [7:0] exp;
        int cyc;
        for (int i = 0; i < 7; i++) begin
            start8(ta[i], tn[i], te[i]);
            wait_out8(cyc);
            exp = q8.pop_front();
            $display("txn8 a=%h n=%0d y=%h exp=%h lat=%0d", ta[i], tn[i], bus8.y, exp, cyc);
            checks++;
            if (cyc !== SW) begin
                errors++;
                $display("FAIL latency8: got %0d want %0d", cyc, SW);
            end
            checks++;
            if (bus8.y !== exp) begin
                errors++;
                $display("FAIL directed8: got %h want %h", bus8.y, exp);
            end
            consume8();
            checks++;
            if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL release8: got vld=%b rdy=%b want 0 1", bus8.out_valid, bus8.in_ready);
            end
        end
    endtask

    task automatic test_inverse_sweep;
        logic [7:0] exp;
        int cyc;
        for (int av = 0; av < 256; av++) begin
            for (int nv = 0; nv < 8; nv++) begin
                start8(rotl8(8'(av), nv), 3'(nv), 8'(av));
                wait_out8(cyc);
                exp = q8.pop_front();
                $display("txn8 a=%h n=%0d y=%h exp=%h lat=%0d", rotl8(8'(av), nv), nv, bus8.y, exp, cyc);
                checks++;
                if (bus8.y !== exp || cyc !== SW) begin
                    errors++;
                    $display("FAIL inverse8: got y=%h lat=%0d want y=%h lat=%0d", bus8.y, cyc, exp, SW);
                end
                consume8();
            end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp;
        int cyc;
        start8(8'hC3, 3'd2, rotr8(8'hC3, 2));
        wait_out8(cyc);
        exp = q8.pop_front();
        bus8.in_valid = 1'b1;
        bus8.a = 8'h11;
        bus8.n = 3'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus8.y !== exp || bus8.out_valid !== 1'b1 || bus8.busy !== 1'b1 || bus8.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold8: got y=%h vld=%b busy=%b rdy=%b want %h 1 1 0",
                         bus8.y, bus8.out_valid, bus8.busy, bus8.in_ready, exp);
            end
        end
        $display("txn8 a=c3 n=2 y=%h exp=%h held=4", bus8.y, exp);
        bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.out_ready = 1'b0;
        checks++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release8: got rdy=%b vld=%b busy=%b want 1 0 0",
                     bus8.in_ready, bus8.out_valid, bus8.busy);
        end
        q8.push_back(rotr8(8'h11, 1));
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        checks++;
        if (bus8.busy !== 1'b1 || bus8.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept8: got busy=%b rdy=%b want 1 0", bus8.busy, bus8.in_ready);
        end
        wait_out8(cyc);
        exp = q8.pop_front();
        $display("txn8 a=11 n=1 y=%h exp=%h lat=%0d", bus8.y, exp, cyc);
        checks++;
        if (bus8.y !== exp || cyc !== SW) begin
            errors++;
            $display("FAIL hold_next8: got y=%h lat=%0d want y=%h lat=%0d", bus8.y, cyc, exp, SW);
        end
        consume8();
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        int cyc;
        start8(8'h3C, 3'd6, rotr8(8'h3C, 6));
        // Inputs change after acceptance and in_valid stays high across the transaction.
        bus8.in_valid = 1'b1;
        bus8.a = 8'hE1;
        bus8.n = 3'd3;
        wait_out8(cyc);
        exp = q8.pop_front();
        $display("txn8 a=3c n=6 y=%h exp=%h lat=%0d", bus8.y, exp, cyc);
        checks++;
        if (bus8.y !== exp || cyc !== SW) begin
            errors++;
            $display("FAIL b2b_first8: got y=%h lat=%0d want y=%h lat=%0d", bus8.y, cyc, exp, SW);
        end
        bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.out_ready = 1'b0;
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle8: got rdy=%b want 1", bus8.in_ready);
        end
        q8.push_back(rotr8(8'hE1, 3));
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        wait_out8(cyc);
        exp = q8.pop_front();
        $display("txn8 a=e1 n=3 y=%h exp=%h lat=%0d", bus8.y, exp, cyc);
        checks++;
        if (bus8.y !== exp || cyc !== SW) begin
            errors++;
            $display("FAIL b2b_second8: got y=%h lat=%0d want y=%h lat=%0d", bus8.y, cyc, exp, SW);
        end
        consume8();
    endtask

    task automatic test_reset_mid_rot;
        logic [7:0] exp;
        int cyc;
        start8(8'hAA, 3'd7, rotr8(8'hAA, 7));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0 || bus8.y !== 8'h00) begin
            errors++;
            $display("FAIL midreset8: got rdy=%b vld=%b busy=%b y=%h want 1 0 0 00",
                     bus8.in_ready, bus8.out_valid, bus8.busy, bus8.y);
        end
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start8(8'h0F, 3'd4, 8'hF0);
        wait_out8(cyc);
        exp = q8.pop_front();
        $display("txn8 a=0f n=4 y=%h exp=%h lat=%0d", bus8.y, exp, cyc);
        checks++;
        if (bus8.y !== exp || cyc !== SW) begin
            errors++;
            $display("FAIL post_reset8: got y=%h lat=%0d want y=%h lat=%0d", bus8.y, cyc, exp, SW);
        end
        consume8();
    endtask

    task automatic test_dw5;
        logic [4:0] ta [4] = '{5'b00011, 5'b10110, 5'b10110, 5'b00001};
        logic [2:0] tn [4] = '{3'd7, 3'd5, 3'd0, 3'd6};
        logic [4:0] te [4] = '{5'b11000, 5'b10110, 5'b10110, 5'b10000};
        logic [4:0] exp;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            start5(ta[i], tn[i], te[i]);
            wait_out5(cyc);
            exp = q5.pop_front();
            $display("txn5 a=%b n=%0d y=%b exp=%b lat=%0d", ta[i], tn[i], bus5.y, exp, cyc);
            checks++;
            if (bus5.y !== exp || cyc !== SW) begin
                errors++;
                $display("FAIL directed5: got y=%b lat=%0d want y=%b lat=%0d", bus5.y, cyc, exp, SW);
            end
            consume5();
        end
        for (int av = 0; av < 32; av++) begin
            for (int nv = 0; nv < 8; nv++) begin
                start5(5'(av), 3'(nv), rotr5(5'(av), nv));
                wait_out5(cyc);
                exp = q5.pop_front();
                $display("txn5 a=%b n=%0d y=%b exp=%b lat=%0d", 5'(av), nv, bus5.y, exp, cyc);
                checks++;
                if (bus5.y !== exp || cyc !== SW) begin
                    errors++;
                    $display("FAIL sweep5: got y=%b lat=%0d want y=%b lat=%0d", bus5.y, cyc, exp, SW);
                end
                consume5();
            end
        end
    endtask

    initial begin
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.n = '0; bus8.out_ready = 1'b0;
        bus5.in_valid = 1'b0; bus5.a = '0; bus5.n = '0; bus5.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_rot();
        test_dw5();
        test_inverse_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
